// File: rtl/idct_seq_pkg.sv
// Shared types and constants for the 8x8 IDCT block sequencer.
// The state encoding, block geometry and datapath mode codes live here.
package idct_seq_pkg;

   localparam int N         = 8;
   localparam int BLK       = N * N;
   localparam int W_DEFAULT = 16;

   localparam logic DP_MODE_ROW = 1'b0;
   localparam logic DP_MODE_COL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ROW  = 3'd2,
      ST_COL  = 3'd3,
      ST_OUT  = 3'd4
   } state_t;

endpackage

// File: rtl/idct_seq_mem.sv
// 8x8 register array with raster, row-vector and column-vector access.
// Vector element k sits in bits [W*k+W-1:W*k]; reads are combinational.
module idct_seq_mem
   import idct_seq_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic           clock,
   input  logic           wr_en,
   input  logic [5:0]     wr_addr,
   input  logic [W-1:0]   wr_data,
   input  logic [5:0]     rd_addr,
   output logic [W-1:0]   rd_data,
   input  logic [2:0]     row_rd_idx,
   output logic [N*W-1:0] row_rd_data,
   input  logic           row_wr_en,
   input  logic [2:0]     row_wr_idx,
   input  logic [N*W-1:0] row_wr_data,
   input  logic [2:0]     col_rd_idx,
   output logic [N*W-1:0] col_rd_data,
   input  logic           col_wr_en,
   input  logic [2:0]     col_wr_idx,
   input  logic [N*W-1:0] col_wr_data
);

   logic [W-1:0] cell_q [BLK];

   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            logic [W-1:0] cell_reg;

            // Only one write port is ever active per instance; priority just keeps it latch-free.
            always_ff @(posedge clock) begin
               if (wr_en && (wr_addr == 6'(gi * N + gj))) begin
                  cell_reg <= wr_data;
               end else if (row_wr_en && (row_wr_idx == 3'(gi))) begin
                  cell_reg <= row_wr_data[W*gj +: W];
               end else if (col_wr_en && (col_wr_idx == 3'(gj))) begin
                  cell_reg <= col_wr_data[W*gi +: W];
               end
            end

            assign cell_q[gi*N + gj] = cell_reg;
         end

         assign row_rd_data[W*gi +: W] = cell_q[{row_rd_idx, 3'(gi)}];
         assign col_rd_data[W*gi +: W] = cell_q[{3'(gi), col_rd_idx}];
      end
   endgenerate

   assign rd_data = cell_q[rd_addr];

endmodule

// File: rtl/idct_block_sequencer.sv
// Block sequencer: loads 64 coefficients, runs row then column passes through
// the shared 1-D IDCT datapath via a transpose store, and streams the result.
module idct_block_sequencer
   import idct_seq_pkg::*;
#(
   parameter int W       = W_DEFAULT,
   parameter int N       = 8,
   parameter int TIMEOUT = 255
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic           dp_in_valid,
   output logic [N*W-1:0] dp_in_data,
   output logic           dp_mode,
   input  logic           dp_out_valid,
   input  logic [N*W-1:0] dp_out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic           busy,
   output logic           err
);

   localparam int         WD_W     = $clog2(TIMEOUT + 1);
   localparam logic [5:0] LAST_IDX = 6'(BLK - 1);

   state_t          state_reg, state_next;
   logic [5:0]      ld_cnt_reg, ld_cnt_next;
   logic [5:0]      out_cnt_reg, out_cnt_next;
   logic [3:0]      iss_cnt_reg, iss_cnt_next;
   logic [3:0]      res_cnt_reg, res_cnt_next;
   logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
   logic            err_reg, err_next;

   logic            pass_active;
   logic            iss_open;
   logic            res_open;
   logic            res_accept;
   logic            res_spurious;
   logic            wd_active;
   logic            timeout;
   logic            in_fire;
   logic            out_fire;
   logic            a_col_wr;
   logic            t_row_wr;
   logic [N*W-1:0]  a_row_data;
   logic [N*W-1:0]  t_col_data;
   logic [N*W-1:0]  a_col_unused;
   logic [N*W-1:0]  t_row_unused;
   logic [W-1:0]    t_rd_unused;

   assign pass_active  = (state_reg == ST_ROW) || (state_reg == ST_COL);
   assign iss_open     = (iss_cnt_reg != 4'd8);
   assign res_open     = (res_cnt_reg != 4'd8);
   assign res_accept   = reset && dp_out_valid && pass_active && res_open;
   assign res_spurious = reset && dp_out_valid && !res_accept;
   // Watchdog only runs once every vector of the pass has been issued.
   assign wd_active    = pass_active && !iss_open && res_open;
   assign timeout      = wd_active && (wd_cnt_reg == WD_W'(TIMEOUT - 1));
   assign in_fire      = in_valid && in_ready;
   assign out_fire     = out_valid && out_ready;
   assign a_col_wr     = res_accept && (state_reg == ST_COL);
   assign t_row_wr     = res_accept && (state_reg == ST_ROW);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         ld_cnt_reg  <= '0;
         out_cnt_reg <= '0;
         iss_cnt_reg <= '0;
         res_cnt_reg <= '0;
         wd_cnt_reg  <= '0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ld_cnt_reg  <= ld_cnt_next;
         out_cnt_reg <= out_cnt_next;
         iss_cnt_reg <= iss_cnt_next;
         res_cnt_reg <= res_cnt_next;
         wd_cnt_reg  <= wd_cnt_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      ld_cnt_next  = ld_cnt_reg;
      out_cnt_next = out_cnt_reg;
      iss_cnt_next = iss_cnt_reg + {3'd0, dp_in_valid};
      res_cnt_next = res_cnt_reg + {3'd0, res_accept};
      wd_cnt_next  = wd_active ? (wd_cnt_reg + WD_W'(1)) : wd_cnt_reg;
      err_next     = err_reg || res_spurious || timeout;

      case (state_reg)
         ST_IDLE: begin
            if (in_fire) begin
               ld_cnt_next = ld_cnt_reg + 6'd1;
               state_next  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_fire) begin
               ld_cnt_next = ld_cnt_reg + 6'd1;
               if (ld_cnt_reg == LAST_IDX) begin
                  state_next = ST_ROW;
               end
            end
         end
         ST_ROW, ST_COL: begin
            if (timeout) begin
               // Abandon the partial block; nothing is streamed out.
               state_next   = ST_IDLE;
               iss_cnt_next = '0;
               res_cnt_next = '0;
               wd_cnt_next  = '0;
            end else if ((iss_cnt_next == 4'd8) && (res_cnt_next == 4'd8)) begin
               if (state_reg == ST_ROW) begin
                  state_next = ST_COL;
               end else begin
                  state_next = ST_OUT;
               end
               iss_cnt_next = '0;
               res_cnt_next = '0;
               wd_cnt_next  = '0;
            end
         end
         ST_OUT: begin
            if (out_fire) begin
               out_cnt_next = out_cnt_reg + 6'd1;
               if (out_cnt_reg == LAST_IDX) begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      in_ready    = 1'b0;
      dp_in_valid = 1'b0;
      dp_mode     = DP_MODE_ROW;
      out_valid   = 1'b0;
      busy        = 1'b0;
      if (reset) begin
         case (state_reg)
            ST_IDLE: begin
               in_ready = 1'b1;
            end
            ST_LOAD: begin
               in_ready = 1'b1;
               busy     = 1'b1;
            end
            ST_ROW: begin
               busy        = 1'b1;
               dp_in_valid = iss_open;
            end
            ST_COL: begin
               busy        = 1'b1;
               dp_in_valid = iss_open;
               dp_mode     = DP_MODE_COL;
            end
            ST_OUT: begin
               busy      = 1'b1;
               out_valid = 1'b1;
            end
            default: begin
               busy = 1'b1;
            end
         endcase
      end
   end

   assign err        = err_reg && reset;
   assign dp_in_data = (state_reg == ST_COL) ? t_col_data : a_row_data;

   // A holds the input block, feeds the row pass and receives the column results.
   idct_seq_mem #(.W(W)) u_mem_a (
      .clock       (clock),
      .wr_en       (in_fire),
      .wr_addr     (ld_cnt_reg),
      .wr_data     (in_data),
      .rd_addr     (out_cnt_reg),
      .rd_data     (out_data),
      .row_rd_idx  (iss_cnt_reg[2:0]),
      .row_rd_data (a_row_data),
      .row_wr_en   (1'b0),
      .row_wr_idx  (3'd0),
      .row_wr_data ({(N*W){1'b0}}),
      .col_rd_idx  (3'd0),
      .col_rd_data (a_col_unused),
      .col_wr_en   (a_col_wr),
      .col_wr_idx  (res_cnt_reg[2:0]),
      .col_wr_data (dp_out_data)
   );

   // T is the transpose store: written by rows, read by columns.
   idct_seq_mem #(.W(W)) u_mem_t (
      .clock       (clock),
      .wr_en       (1'b0),
      .wr_addr     (6'd0),
      .wr_data     ({W{1'b0}}),
      .rd_addr     (6'd0),
      .rd_data     (t_rd_unused),
      .row_rd_idx  (3'd0),
      .row_rd_data (t_row_unused),
      .row_wr_en   (t_row_wr),
      .row_wr_idx  (res_cnt_reg[2:0]),
      .row_wr_data (dp_out_data),
      .col_rd_idx  (iss_cnt_reg[2:0]),
      .col_rd_data (t_col_data),
      .col_wr_en   (1'b0),
      .col_wr_idx  (3'd0),
      .col_wr_data ({(N*W){1'b0}})
   );

endmodule

// File: tb/tb_idct_block_sequencer.sv
// Scoreboard bench for idct_block_sequencer with a behavioural pipelined datapath.
// Expected issue vectors and output samples are queued; a monitor pops and compares.
module tb_idct_block_sequencer;

   localparam int TW = 16;
   localparam int TN = 8;
   localparam int TO = 255;

   typedef logic [255:0] wide_t;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid;
   logic              in_ready;
   logic [TW-1:0]     in_data;
   logic              dp_in_valid;
   logic [TN*TW-1:0]  dp_in_data;
   logic              dp_mode;
   logic              dp_out_valid;
   logic [TN*TW-1:0]  dp_out_data;
   logic              out_valid;
   logic              out_ready;
   logic [TW-1:0]     out_data;
   logic              busy;
   logic              err;

   int                chk_cnt = 0;
   int                pass_cnt = 0;
   logic [TW-1:0]     exp_q [$];
   logic [TN*TW:0]    dp_q [$];
   logic [TW-1:0]     blk [64];
   bit                dp_chk_en = 1'b1;
   bit                dp_en = 1'b1;
   bit                dp_neg = 1'b0;
   bit                bp_en = 1'b0;
   bit                spur = 1'b0;
   int                lat = 5;
   int                cyc = 0;
   int                bp_ph = 0;
   int                row_issue_cnt = 0;
   int                e8 = 0;
   int                out_seen = 0;
   int                wt_n;
   int                wt_m;
   logic              held_valid = 1'b0;
   logic [TW-1:0]     held_data;
   logic              pipe_v [8];
   logic [TN*TW-1:0]  pipe_d [8];

   always #5 clock = ~clock;

   idct_block_sequencer #(.W(TW), .N(TN), .TIMEOUT(TO)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .dp_in_valid  (dp_in_valid),
      .dp_in_data   (dp_in_data),
      .dp_mode      (dp_mode),
      .dp_out_valid (dp_out_valid),
      .dp_out_data  (dp_out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .busy         (busy),
      .err          (err)
   );

   function automatic logic [TN*TW-1:0] dp_fn(input logic [TN*TW-1:0] v, input bit neg);
      logic [TN*TW-1:0] r;
      for (int k = 0; k < TN; k++) begin
         r[k*TW +: TW] = neg ? (16'd0 - v[k*TW +: TW]) : v[k*TW +: TW];
      end
      return r;
   endfunction

   // Behavioural datapath: fixed-latency pipeline, reset along with the DUT.
   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) pipe_v[i] <= 1'b0;
      end else begin
         pipe_v[0] <= dp_in_valid && dp_en;
         pipe_d[0] <= dp_fn(dp_in_data, dp_neg);
         for (int i = 1; i < 8; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign dp_out_valid = pipe_v[lat-1] | spur;
   assign dp_out_data  = pipe_d[lat-1];

   initial begin
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clock);
         if (bp_en) begin
            out_ready = ((bp_ph % 4) == 0) || ((bp_ph % 4) == 3);
            bp_ph++;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   task automatic check(input string nm, input wide_t act, input wide_t req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, req);
   endtask

   task automatic fail_now(input string nm);
      chk_cnt++;
      $display("FAIL %s: got event expected none", nm);
   endtask

   // Monitor: compares issue vectors and output samples against the queues.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (reset) begin
            if (out_valid && held_valid)
               check("out_stable", wide_t'(out_data), wide_t'(held_data));
            if (out_valid && out_ready) begin
               out_seen++;
               if (exp_q.size() == 0) fail_now("unexpected_out");
               else check("out_data", wide_t'(out_data), wide_t'(exp_q.pop_front()));
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            if (dp_in_valid) begin
               if (!dp_mode) begin
                  row_issue_cnt++;
                  if (row_issue_cnt == 8) e8 = cyc + 1;
               end
               if (dp_chk_en) begin
                  if (dp_q.size() == 0) fail_now("unexpected_issue");
                  else check("dp_issue", wide_t'({dp_mode, dp_in_data}), wide_t'(dp_q.pop_front()));
               end
            end
         end else begin
            held_valid = 1'b0;
         end
      end
   end

   task automatic plan_block(input bit neg, input bit full);
      logic [TN*TW-1:0] v;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) v[k*TW +: TW] = blk[r*8 + k];
         dp_q.push_back({1'b0, v});
      end
      if (full) begin
         for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++)
               v[k*TW +: TW] = neg ? (16'd0 - blk[k*8 + c]) : blk[k*8 + c];
            dp_q.push_back({1'b1, v});
         end
         for (int i = 0; i < 64; i++) exp_q.push_back(blk[i]);
      end
   endtask

   task automatic load_block();
      int guard;
      for (int i = 0; i < 64; i++) begin
         @(negedge clock);
         in_valid = 1'b1;
         in_data  = blk[i];
         guard = 0;
         while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
         end
         if (guard >= 100) fail_now("load_stall");
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int n;
      n = 0;
      @(negedge clock);
      #1;
      while ((exp_q.size() != 0 || dp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clock);
         #1;
         n++;
      end
      check({nm, "_outputs_left"}, wide_t'(exp_q.size()), wide_t'(0));
      check({nm, "_issues_left"}, wide_t'(dp_q.size()), wide_t'(0));
      check({nm, "_busy"}, wide_t'(busy), wide_t'(0));
      check({nm, "_err"}, wide_t'(err), wide_t'(0));
   endtask

   task automatic pulse_reset(input int n);
      @(negedge clock);
      reset = 1'b0;
      repeat (n) @(negedge clock);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

   initial begin
      in_valid = 1'b0;
      in_data  = '0;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_in_ready_low", wide_t'(in_ready), wide_t'(0));
      reset = 1'b1;
      #1;
      check("rst_in_ready", wide_t'(in_ready), wide_t'(1));
      check("rst_out_valid", wide_t'(out_valid), wide_t'(0));
      check("rst_busy", wide_t'(busy), wide_t'(0));
      check("rst_err", wide_t'(err), wide_t'(0));
      check("rst_dp_in_valid", wide_t'(dp_in_valid), wide_t'(0));

      // Identity loopback, latency 5
      for (int i = 0; i < 64; i++) blk[i] = 16'(i);
      lat = 5; dp_neg = 1'b0; out_seen = 0;
      plan_block(1'b0, 1'b1);
      load_block();
      wait_idle("ident", 600);
      check("ident_count", wide_t'(out_seen), wide_t'(64));

      // Negating datapath, latency 1
      lat = 1; dp_neg = 1'b1; out_seen = 0;
      plan_block(1'b1, 1'b1);
      load_block();
      wait_idle("negate", 600);
      check("negate_count", wide_t'(out_seen), wide_t'(64));

      // Output backpressure 1,0,0,1
      for (int i = 0; i < 64; i++) blk[i] = 16'(i * 3 + 16'h1234);
      lat = 5; dp_neg = 1'b0; out_seen = 0; bp_ph = 0; bp_en = 1'b1;
      plan_block(1'b0, 1'b1);
      load_block();
      wait_idle("bp", 1000);
      repeat (4) @(negedge clock);
      bp_en = 1'b0;
      check("bp_count", wide_t'(out_seen), wide_t'(64));

      // Watchdog: datapath never answers
      for (int i = 0; i < 64; i++) blk[i] = 16'(16'hA000 + i);
      dp_en = 1'b0; row_issue_cnt = 0; e8 = 0;
      plan_block(1'b0, 1'b0);
      load_block();
      wt_n = 0; wt_m = -1;
      while (wt_n < 600 && wt_m < 0) begin
         @(negedge clock);
         #1;
         if (err) wt_m = cyc;
         wt_n++;
      end
      check("timeout_latency", wide_t'(wt_m - e8), wide_t'(TO));
      check("timeout_busy", wide_t'(busy), wide_t'(0));
      check("timeout_in_ready", wide_t'(in_ready), wide_t'(1));
      check("timeout_issues_left", wide_t'(dp_q.size()), wide_t'(0));
      dp_en = 1'b1;

      // Spurious result in IDLE
      pulse_reset(2);
      check("rst_clears_err", wide_t'(err), wide_t'(0));
      @(negedge clock);
      spur = 1'b1;
      @(negedge clock);
      spur = 1'b0;
      #1;
      check("spur_err", wide_t'(err), wide_t'(1));
      check("spur_busy", wide_t'(busy), wide_t'(0));
      check("spur_in_ready", wide_t'(in_ready), wide_t'(1));

      // Reset in the middle of the column pass, then a clean block
      pulse_reset(2);
      for (int i = 0; i < 64; i++) blk[i] = 16'(16'h0500 + i);
      lat = 5; dp_neg = 1'b0; dp_chk_en = 1'b0;
      load_block();
      wt_n = 0;
      while (!(dp_in_valid && dp_mode) && wt_n < 200) begin
         @(negedge clock);
         #1;
         wt_n++;
      end
      check("midcol_reached", wide_t'(dp_in_valid && dp_mode), wide_t'(1));
      reset = 1'b0;
      #1;
      check("midcol_rst_out_valid", wide_t'(out_valid), wide_t'(0));
      check("midcol_rst_in_ready", wide_t'(in_ready), wide_t'(0));
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("midcol_busy", wide_t'(busy), wide_t'(0));
      check("midcol_out_valid", wide_t'(out_valid), wide_t'(0));
      check("midcol_in_ready", wide_t'(in_ready), wide_t'(1));
      dp_chk_en = 1'b1;
      for (int i = 0; i < 64; i++) blk[i] = 16'(16'hFFC0 + i);
      dp_neg = 1'b1; out_seen = 0;
      plan_block(1'b1, 1'b1);
      load_block();
      wait_idle("after_rst", 600);
      check("after_rst_count", wide_t'(out_seen), wide_t'(64));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/idct_block_sequencer.md
Name: idct_block_sequencer

Overview:
Sequences one 8x8 block through the shared, fully pipelined 1-D IDCT datapath built from the 16-bit ADD/MUL/SHL/SHR/CLIP/W-constant graph.
- First pass: row transforms. Second pass: column transforms, through a transpose store.
- Accepts 64 coefficients on a valid/ready stream and emits 64 samples in raster order.
- Sits between the coefficient source and the datapath instance; owns all block-level buffering and ordering.

Parameters:
W, 16, sample/coefficient width in bits
N, 8, vector length / block dimension (fixed 8; other values unsupported)
TIMEOUT, 255, max cycles from last vector issue to last result before error

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  coefficient valid
in_ready  out  1  coefficient accepted when in_valid&in_ready
in_data  in  W  coefficient, raster order (row-major)
dp_in_valid  out  1  vector issue strobe to datapath
dp_in_data  out  N*W  vector; element k in bits [W*k+W-1:W*k]
dp_mode  out  1  0=row pass, 1=column pass; valid with dp_in_valid
dp_out_valid  in  1  datapath result vector valid
dp_out_data  in  N*W  result vector, same packing
out_valid  out  1  output sample valid
out_ready  in  1  sink ready
out_data  out  W  output sample, raster order
busy  out  1  high in any state except IDLE
err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; all counters are zeroed.
  - Outputs: in_ready=0 during reset, dp_in_valid=0, dp_mode=0, out_valid=0, busy=0, err=0.
  - Buffer contents are not cleared.
- States and transitions:
  - IDLE: in_ready=1. First handshake stores word 0 and moves to LOAD with ld_cnt=1.
  - LOAD: in_ready=1. Word i is stored at A[i/8][i%8]. After word 63 is accepted, go to ROW; in_ready drops the next cycle.
  - ROW: issue rows r=0..7 on 8 consecutive cycles. dp_in_data={A[r][7..0]}, dp_mode=0.
    - No datapath backpressure (II=1).
    - Result vector r (arrival order) element j is written to T[r][j].
    - Go to COL when 8 results have been received.
  - COL: issue columns c=0..7 on 8 consecutive cycles. dp_in_data={T[7..0][c]}, dp_mode=1.
    - Result vector c element j is written to A[j][c] (A is reused).
    - Go to OUT after 8 results.
  - OUT: stream A in raster order, out_data=A[k/8][k%8].
    - Advance k only on out_valid&out_ready; out_data is held stable while stalled.
    - After word 63 is accepted, go to IDLE.
- Result handling:
  - Results may arrive while issue is still in progress (datapath latency < 8); they are accepted the same cycle.
  - dp_out_valid outside ROW/COL, or beyond 8 per pass: err=1, data dropped, state unaffected.
- Watchdog:
  - Counts cycles in ROW/COL after the 8th issue, while results are outstanding.
  - If it reaches TIMEOUT: err=1, return to IDLE. Partial block is discarded; no output is produced.
- Latency: 64 load cycles, then 8 + L_dp (row pass), then 8 + L_dp (column pass), then 64 output cycles at full out_ready.
  - L_dp is the datapath latency in cycles.
  - Data bits are never modified by this block: no width change, no saturation. Clipping belongs to the datapath.
- No overlap between blocks: in_ready=0 from ROW entry until return to IDLE.

Decomposition:
- Package idct_seq_pkg holds:
  - state encoding (IDLE, LOAD, ROW, COL, OUT)
  - constants N=8, BLK=64
  - DP_MODE_ROW=0, DP_MODE_COL=1
  - default W
- Sub-module idct_seq_mem: 8x8xW register array. Ports:
  - scalar raster write, scalar raster read
  - row-vector read, row-vector write
  - column-vector read, column-vector write
- The sequencer instantiates idct_seq_mem twice (A and T); its own logic is the FSM, counters and watchdog.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, release -> in_ready=1, out_valid=0, busy=0, err=0, dp_in_valid=0.
2. Identity loopback: bench datapath is a 5-cycle passthrough; load 0..63 -> 8 row issues (first dp_in_data = {7,6,...,0}, dp_mode=0), then 8 column issues (first = {56,48,...,0}, dp_mode=1), then output 0..63 in order, err=0.
3. Negate datapath (each element -> -x mod 2^16), load 0..63 -> output equals input (double negation); with a latency-1 datapath, results overlap issue with no loss.
4. Output backpressure: out_ready toggles 1,0,0,1 repeating -> exactly 64 outputs, no duplicates or drops, out_data stable while stalled.
5. Timeout: datapath never responds -> err=1 exactly TIMEOUT cycles after the 8th row issue; state returns to IDLE; in_ready=1 next cycle.
6. Faults: spurious dp_out_valid in IDLE -> err=1, busy stays 0; separately, reset=0 for 1 cycle mid-COL -> IDLE, out_valid=0, and a following block of 64 words processes correctly.
